// File: rtl/axi_pkg.sv
// Shared constants and FSM state types for the AXI4 burst slave memory.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axi_slave_mem_if.sv
// AXI4 write (AW/W/B) and read (AR/R) channel bundle between a master and the slave memory.
interface axi_slave_mem_if #(
  parameter int ID_W = 3
);
  // Every channel transfers on a rising edge where valid and ready are both 1.
  // A source holds valid and its payload steady until that edge; ready may change freely.
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;

  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

endinterface

// File: rtl/axi_burst_addr.sv
// Combinational beat-address stepper and burst-wide legality check.
module axi_burst_addr
  import axi_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [7:0]  len,
  input  logic [2:0]  size,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr,
  output logic        err
);

  logic [31:0] incr;
  logic [31:0] wrap_mask;

  always_comb begin
    incr      = 32'd1 << size;
    // WRAP window is (len+1)<<size bytes; only the offset inside it advances
    wrap_mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
    next_addr = addr;
    case (burst)
      BURST_INCR: next_addr = addr + incr;
      BURST_WRAP: next_addr = (addr & ~wrap_mask) | ((addr + incr) & wrap_mask);
      default:    next_addr = addr;
    endcase
    err = (size > 3'd2) || (burst == 2'b11) ||
          ((burst == BURST_WRAP) &&
           !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)));
  end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 burst slave over a word-addressed memory; independent write and read state machines.
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int ID_W  = 3
)(
  input  logic            s_axi_aclk,
  input  logic            s_axi_areset,
  axi_slave_mem_if.slave  s_axi,
  output wr_state_t       wr_state_dbg,
  output rd_state_t       rd_state_dbg
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];

  // ---------------- write path ----------------
  wr_state_t       wr_state, wr_next;
  logic [ID_W-1:0] aw_id;
  logic [31:0]     w_addr, w_next_addr;
  logic [7:0]      aw_len, w_cnt;
  logic [2:0]      aw_size;
  logic [1:0]      aw_burst;
  logic            w_err, w_burst_err, w_range_err, w_last_err, w_beat_err;
  logic            aw_hs, w_beat, w_done;

  axi_burst_addr u_wr_addr (
    .addr(w_addr), .len(aw_len), .size(aw_size), .burst(aw_burst),
    .next_addr(w_next_addr), .err(w_burst_err)
  );

  always_comb begin
    aw_hs       = (wr_state == W_IDLE) && s_axi.awvalid && s_axi.awready;
    w_beat      = (wr_state == W_DATA) && s_axi.wvalid && s_axi.wready;
    w_done      = w_beat && (s_axi.wlast || (w_cnt == aw_len));
    w_range_err = |w_addr[31:AW+2];
    w_last_err  = s_axi.wlast != (w_cnt == aw_len);
    w_beat_err  = w_burst_err || w_range_err || w_last_err;
    wr_next     = wr_state;
    case (wr_state)
      W_IDLE:  if (aw_hs) wr_next = W_DATA;
      W_DATA:  if (w_done) wr_next = W_RESP;
      W_RESP:  if (s_axi.bvalid && s_axi.bready) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      wr_state      <= W_IDLE;
      s_axi.awready <= 1'b0;
      s_axi.wready  <= 1'b0;
      s_axi.bvalid  <= 1'b0;
      s_axi.bid     <= '0;
      s_axi.bresp   <= RESP_OKAY;
      aw_id         <= '0;
      w_addr        <= '0;
      aw_len        <= '0;
      aw_size       <= '0;
      aw_burst      <= '0;
      w_cnt         <= '0;
      w_err         <= 1'b0;
    end else begin
      wr_state      <= wr_next;
      s_axi.awready <= (wr_next == W_IDLE);
      s_axi.wready  <= (wr_next == W_DATA);
      s_axi.bvalid  <= (wr_next == W_RESP);
      if (aw_hs) begin
        aw_id    <= s_axi.awid;
        w_addr   <= s_axi.awaddr;
        aw_len   <= s_axi.awlen;
        aw_size  <= s_axi.awsize;
        aw_burst <= s_axi.awburst;
        w_cnt    <= '0;
        w_err    <= 1'b0;
      end
      if (w_beat) begin
        w_addr <= w_next_addr;
        w_cnt  <= w_cnt + 8'd1;
        w_err  <= w_err | w_beat_err;
      end
      if (w_done) begin
        s_axi.bid   <= aw_id;
        s_axi.bresp <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // Memory has no reset so contents survive s_axi_areset
  always_ff @(posedge s_axi_aclk) begin
    if (w_beat && !w_burst_err && !w_range_err) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi.wstrb[b]) mem[w_addr[AW+1:2]][8*b +: 8] <= s_axi.wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  rd_state_t   rd_state, rd_next;
  logic [31:0] r_addr, r_cur_addr, r_next_addr, r_beat_data;
  logic [7:0]  ar_len, r_cur_len, r_cnt;
  logic [2:0]  ar_size, r_cur_size;
  logic [1:0]  ar_burst, r_cur_burst;
  logic        r_burst_err, r_beat_err, ar_hs, r_hs;

  axi_burst_addr u_rd_addr (
    .addr(r_cur_addr), .len(r_cur_len), .size(r_cur_size), .burst(r_cur_burst),
    .next_addr(r_next_addr), .err(r_burst_err)
  );

  always_comb begin
    ar_hs = (rd_state == R_IDLE) && s_axi.arvalid && s_axi.arready;
    r_hs  = (rd_state == R_DATA) && s_axi.rvalid && s_axi.rready;
    // In R_IDLE the incoming request drives the stepper so beat 0 loads at the AR edge
    if (rd_state == R_IDLE) begin
      r_cur_addr  = s_axi.araddr;
      r_cur_len   = s_axi.arlen;
      r_cur_size  = s_axi.arsize;
      r_cur_burst = s_axi.arburst;
    end else begin
      r_cur_addr  = r_addr;
      r_cur_len   = ar_len;
      r_cur_size  = ar_size;
      r_cur_burst = ar_burst;
    end
    r_beat_err  = r_burst_err || (|r_cur_addr[31:AW+2]);
    r_beat_data = r_beat_err ? 32'd0 : mem[r_cur_addr[AW+1:2]];
    rd_next     = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_hs) rd_next = R_DATA;
      R_DATA:  if (r_hs && s_axi.rlast) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      rd_state      <= R_IDLE;
      s_axi.arready <= 1'b0;
      s_axi.rvalid  <= 1'b0;
      s_axi.rlast   <= 1'b0;
      s_axi.rdata   <= '0;
      s_axi.rresp   <= RESP_OKAY;
      s_axi.rid     <= '0;
      r_addr        <= '0;
      ar_len        <= '0;
      ar_size       <= '0;
      ar_burst      <= '0;
      r_cnt         <= '0;
    end else begin
      rd_state      <= rd_next;
      s_axi.arready <= (rd_next == R_IDLE);
      s_axi.rvalid  <= (rd_next == R_DATA);
      if (ar_hs) begin
        ar_len      <= s_axi.arlen;
        ar_size     <= s_axi.arsize;
        ar_burst    <= s_axi.arburst;
        s_axi.rid   <= s_axi.arid;
        r_addr      <= r_next_addr;
        r_cnt       <= '0;
        s_axi.rdata <= r_beat_data;
        s_axi.rresp <= r_beat_err ? RESP_SLVERR : RESP_OKAY;
        s_axi.rlast <= (s_axi.arlen == 8'd0);
      end else if (r_hs) begin
        if (s_axi.rlast) begin
          s_axi.rlast <= 1'b0;
        end else begin
          s_axi.rdata <= r_beat_data;
          s_axi.rresp <= r_beat_err ? RESP_SLVERR : RESP_OKAY;
          s_axi.rlast <= ((r_cnt + 8'd1) == ar_len);
          r_cnt       <= r_cnt + 8'd1;
          r_addr      <= r_next_addr;
        end
      end
    end
  end

  assign wr_state_dbg = wr_state;
  assign rd_state_dbg = rd_state;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Randomized bench for axi_slave_mem against an address-arithmetic memory model.
module tb_axi_slave_mem;
  import axi_pkg::*;

  localparam int DEPTH = 128;
  localparam int ID_W  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_slave_mem_if #(.ID_W(ID_W)) ifc ();
  wr_state_t wr_state_dbg;
  rd_state_t rd_state_dbg;

  axi_slave_mem #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (rst),
    .s_axi        (ifc),
    .wr_state_dbg (wr_state_dbg),
    .rd_state_dbg (rd_state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_mem [DEPTH];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit burst_bad(input int len, input int sz, input logic [1:0] bu);
    return (sz > 2) || (bu == 2'b11) ||
           ((bu == BURST_WRAP) && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, input int sz,
                                            input logic [1:0] bu, input int i);
    int unsigned nb, wb, base;
    nb = 1 << sz;
    wb = (len + 1) * nb;
    if (bu == BURST_FIXED) return a;
    if (bu == BURST_WRAP) begin
      base = (a / wb) * wb;
      return base + ((a - base + i * nb) % wb);
    end
    return a + i * nb;
  endfunction

  task automatic model_write(input logic [31:0] ba, input logic [31:0] d, input logic [3:0] s);
    int wi;
    wi = int'(ba >> 2);
    for (int b = 0; b < 4; b++)
      if (s[b]) exp_mem[wi][8*b +: 8] = d[8*b +: 8];
  endtask

  // ---------------- driver tasks ----------------
  task automatic aw_send(input logic [ID_W-1:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
    int t = 0;
    ifc.awid = id; ifc.awaddr = a; ifc.awlen = len; ifc.awsize = sz; ifc.awburst = bu;
    ifc.awvalid = 1'b1;
    @(negedge clk);
    while (!ifc.awready && t < 100) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    ifc.awvalid = 1'b0;
    check("aw_to_wready", 32'(ifc.wready), 32'd1);
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s, input bit last);
    int t = 0;
    ifc.wvalid = 1'b0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    ifc.wdata = d; ifc.wstrb = s; ifc.wlast = last; ifc.wvalid = 1'b1;
    @(negedge clk);
    while (!ifc.wready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) check("w_timeout", 32'(t), 32'd0);
    @(posedge clk); #1;
    ifc.wvalid = 1'b0; ifc.wlast = 1'b0;
  endtask

  task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] a, input int len,
                          input int sz, input logic [1:0] bu, input int last_at, input int bdelay);
    int nb;
    bit bad, err;
    logic [31:0] ba;
    nb  = (last_at < len) ? last_at + 1 : len + 1;
    bad = burst_bad(len, sz, bu);
    err = bad || (last_at != len);
    aw_send(id, a, 8'(len), 3'(sz), bu);
    for (int i = 0; i < nb; i++) begin
      w_send(wd[i], ws[i], i == last_at);
      ba = beat_addr(a, len, sz, bu, i);
      if ((ba >> 2) >= DEPTH) err = 1'b1;
      else if (!bad) model_write(ba, wd[i], ws[i]);
    end
    check("b_latency", 32'(ifc.bvalid), 32'd1);
    for (int c = 0; c < bdelay; c++) begin
      @(posedge clk); #1;
      check("b_hold_valid", 32'(ifc.bvalid), 32'd1);
      check("b_hold_id", 32'(ifc.bid), 32'(id));
    end
    ifc.bready = 1'b1;
    @(negedge clk);
    check("bresp", 32'(ifc.bresp), err ? 32'(RESP_SLVERR) : 32'(RESP_OKAY));
    check("bid", 32'(ifc.bid), 32'(id));
    @(posedge clk); #1;
    ifc.bready = 1'b0;
    check("b_done", 32'(ifc.bvalid), 32'd0);
  endtask

  // mode 0: rready always high, 1: toggles every cycle, 2: random
  task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] a, input int len,
                         input int sz, input logic [1:0] bu, input int mode);
    logic [31:0] exp_q[$];
    logic [31:0] resp_q[$];
    logic [31:0] ba, hd;
    logic [1:0]  hr;
    logic        hl;
    bit held = 1'b0, bad;
    int idx = 0, cyc = 0, t = 0;
    bad = burst_bad(len, sz, bu);
    for (int i = 0; i <= len; i++) begin
      ba = beat_addr(a, len, sz, bu, i);
      if (bad || (ba >> 2) >= DEPTH) begin
        exp_q.push_back(32'd0); resp_q.push_back(32'(RESP_SLVERR));
      end else begin
        exp_q.push_back(exp_mem[int'(ba >> 2)]); resp_q.push_back(32'(RESP_OKAY));
      end
    end
    ifc.arid = id; ifc.araddr = a; ifc.arlen = 8'(len); ifc.arsize = 3'(sz); ifc.arburst = bu;
    ifc.arvalid = 1'b1;
    @(negedge clk);
    while (!ifc.arready && t < 100) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    ifc.arvalid = 1'b0;
    check("ar_to_rvalid", 32'(ifc.rvalid), 32'd1);
    while (idx <= len && cyc < 4000) begin
      case (mode)
        0:       ifc.rready = 1'b1;
        1:       ifc.rready = (cyc % 2 == 0);
        default: ifc.rready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (ifc.rvalid) begin
        if (held) begin
          check("r_stable_data", ifc.rdata, hd);
          check("r_stable_resp", 32'(ifc.rresp), 32'(hr));
          check("r_stable_last", 32'(ifc.rlast), 32'(hl));
        end
        if (ifc.rready) begin
          check("rdata", ifc.rdata, exp_q.pop_front());
          check("rresp", 32'(ifc.rresp), resp_q.pop_front());
          check("rlast", 32'(ifc.rlast), 32'(idx == len));
          check("rid", 32'(ifc.rid), 32'(id));
          idx++;
          held = 1'b0;
        end else begin
          held = 1'b1; hd = ifc.rdata; hr = ifc.rresp; hl = ifc.rlast;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    ifc.rready = 1'b0;
    if (idx <= len) check("r_timeout", 32'(idx), 32'(len + 1));
    check("r_done", 32'(ifc.rvalid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, 32'(ifc.awready), 32'd0);
    check({tag, "_wready"},  32'(ifc.wready),  32'd0);
    check({tag, "_bvalid"},  32'(ifc.bvalid),  32'd0);
    check({tag, "_arready"}, 32'(ifc.arready), 32'd0);
    check({tag, "_rvalid"},  32'(ifc.rvalid),  32'd0);
    check({tag, "_rlast"},   32'(ifc.rlast),   32'd0);
    check({tag, "_rdata"},   ifc.rdata,        32'd0);
    check({tag, "_bresp"},   32'(ifc.bresp),   32'd0);
    check({tag, "_rresp"},   32'(ifc.rresp),   32'd0);
    check({tag, "_bid"},     32'(ifc.bid),     32'd0);
    check({tag, "_rid"},     32'(ifc.rid),     32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    ifc.awid = '0; ifc.awaddr = '0; ifc.awlen = '0; ifc.awsize = '0; ifc.awburst = '0;
    ifc.awvalid = 1'b0; ifc.wdata = '0; ifc.wstrb = '0; ifc.wlast = 1'b0; ifc.wvalid = 1'b0;
    ifc.bready = 1'b0; ifc.arid = '0; ifc.araddr = '0; ifc.arlen = '0; ifc.arsize = '0;
    ifc.arburst = '0; ifc.arvalid = 1'b0; ifc.rready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    check("rst_wr_state", 32'(wr_state_dbg), 32'(W_IDLE));
    rst = 1'b0;
    #1;
    check("awready_before_edge", 32'(ifc.awready), 32'd0);
    @(posedge clk); #1;
    check("awready_rise", 32'(ifc.awready), 32'd1);
    check("arready_rise", 32'(ifc.arready), 32'd1);

    // Known contents everywhere before any read
    for (int i = 0; i < DEPTH; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(3'd0, 32'h0, DEPTH - 1, 2, BURST_INCR, DEPTH - 1, 0);

    // INCR write / read
    wd[0] = 32'd1; wd[1] = 32'd5; wd[2] = 32'd25; wd[3] = 32'd125;
    for (int i = 0; i < 4; i++) ws[i] = 4'hF;
    do_write(3'd3, 32'h10, 3, 2, BURST_INCR, 3, 0);
    do_read(3'd5, 32'h10, 3, 2, BURST_INCR, 0);

    // WRAP write, then linear read across the window
    wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
    do_write(3'd1, 32'h18, 3, 2, BURST_WRAP, 3, 0);
    do_read(3'd2, 32'h10, 3, 2, BURST_INCR, 0);
    do_read(3'd2, 32'h18, 3, 2, BURST_WRAP, 0);

    // FIXED write then byte-lane strobe
    wd[0] = 32'd7; wd[1] = 32'd8; wd[2] = 32'd9;
    do_write(3'd4, 32'h20, 2, 2, BURST_FIXED, 2, 0);
    do_read(3'd4, 32'h20, 0, 2, BURST_INCR, 0);
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'b0010;
    do_write(3'd4, 32'h20, 0, 2, BURST_INCR, 0, 0);
    do_read(3'd4, 32'h20, 0, 2, BURST_INCR, 0);

    // Errors: out of range, oversize, early and missing wlast
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(3'd6, 32'h200, 0, 2, BURST_INCR, 0, 0);
    do_read(3'd6, 32'h200, 0, 2, BURST_INCR, 0);
    do_read(3'd6, 32'h1F8, 3, 2, BURST_INCR, 0);
    do_write(3'd7, 32'h30, 1, 3, BURST_INCR, 1, 0);
    do_read(3'd7, 32'h30, 1, 2, BURST_INCR, 0);
    do_write(3'd1, 32'h60, 3, 2, BURST_INCR, 1, 0);
    do_write(3'd2, 32'h70, 2, 2, BURST_INCR, 255, 0);
    do_write(3'd2, 32'h70, 2, 2, BURST_WRAP, 2, 0);
    do_read(3'd0, 32'h60, 7, 2, BURST_INCR, 0);

    // Backpressure and concurrent bursts
    for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(3'd5, 32'h80, 1, 2, BURST_INCR, 1, 5);
    do_read(3'd3, 32'h0, 7, 2, BURST_INCR, 1);
    fork
      do_write(3'd6, 32'h100, 7, 2, BURST_INCR, 7, 2);
      do_read(3'd1, 32'h0, 15, 2, BURST_INCR, 2);
    join
    do_read(3'd1, 32'h100, 7, 2, BURST_INCR, 1);

    // Reset in the middle of a write burst
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    aw_send(3'd2, 32'h40, 8'd3, 3'd2, BURST_INCR);
    w_send(wd[0], 4'hF, 1'b0);
    model_write(32'h40, wd[0], 4'hF);
    w_send(wd[1], 4'hF, 1'b0);
    model_write(32'h44, wd[1], 4'hF);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_awready", 32'(ifc.awready), 32'd1);
    check("post_rst_bvalid", 32'(ifc.bvalid), 32'd0);
    do_read(3'd0, 32'h40, 3, 2, BURST_INCR, 0);

    // Randomized bursts
    for (int it = 0; it < 30; it++) begin
      int sz, len, last_at, r;
      logic [1:0] bu;
      logic [31:0] a;
      sz = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      bu = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if (bu == BURST_WRAP) begin
        r = int'($urandom_range(0, 4));
        len = (r == 4) ? 2 : ((2 << r) - 1);
      end else begin
        len = int'($urandom_range(0, 15));
      end
      a = 32'($urandom_range(0, DEPTH + 4)) * 32'd4;
      if (sz <= 2) a = a + 32'((int'($urandom_range(0, 3)) >> sz) << sz);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        r = int'($urandom_range(0, 9));
        last_at = (r < 8) ? len : ((r == 8) ? 255 : ((len > 0) ? len - 1 : len));
        do_write(3'($urandom), a, len, sz, bu, last_at, int'($urandom_range(0, 2)));
      end else begin
        do_read(3'($urandom), a, len, sz, bu, int'($urandom_range(0, 2)));
      end
    end
    do_read(3'd0, 32'h0, DEPTH - 1, 2, BURST_INCR, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
